// File: rtl/engine_result_port.sv
`timescale 1ns/1ps
// engine_result_port
//    Per-engine result buffer between one Mandelbrot engine and the shared
//    result arbiter that writes the VGA RAM. Finished pixels (RAM address plus
//    iteration count) are queued in a small FIFO. A registered request is
//    raised while results are waiting. On a grant the FIFO head is driven onto
//    the shared OR-bus for that single cycle and popped on the closing edge.
//    After each grant the request stays low for HOLDOFF cycles so the arbiter
//    never samples a stale request.
//
// Parameters
//    ADDR_W   pixel address width
//    ITER_W   iteration-count / colour word width
//    DEPTH    FIFO entries (power of 2, >= 2)
//    HOLDOFF  cycles engine_req stays low after a grant (>= 1)
//    TIMEOUT  cycles a request may wait unacked before timeout_err
//
// Ports
//    clk_iCLK     in   engine clock, rising edge only
//    reset_n      in   asynchronous active-low reset
//    res_valid    in   engine presents a finished pixel
//    res_ready    out  FIFO can accept (push = res_valid & res_ready)
//    res_addr     in   VGA RAM address of the finished pixel
//    res_iter     in   iteration count of the finished pixel
//    engine_req   out  registered request to the arbiter
//    req_ack      in   arbiter grant, one cycle per grant
//    bus_addr     out  FIFO head address while bus_oe, else 0
//    bus_data     out  FIFO head iteration count while bus_oe, else 0
//    bus_oe       out  req_ack while in REQ (combinational)
//    fifo_count   out  entries held
//    timeout_err  out  sticky watchdog flag
//
// Configuration
//    ERP_ACK_TIMEOUT_EN  when defined, a watchdog counts cycles spent waiting
//                        in REQ and sets timeout_err at TIMEOUT. When not
//                        defined, timeout_err is tied low.

module engine_result_port #(
   parameter int ADDR_W  = 19,
   parameter int ITER_W  = 8,
   parameter int DEPTH   = 4,
   parameter int HOLDOFF = 2,
   parameter int TIMEOUT = 1023
) (
   input  logic                     clk_iCLK,
   input  logic                     reset_n,
   input  logic                     res_valid,
   output logic                     res_ready,
   input  logic [ADDR_W-1:0]        res_addr,
   input  logic [ITER_W-1:0]        res_iter,
   output logic                     engine_req,
   input  logic                     req_ack,
   output logic [ADDR_W-1:0]        bus_addr,
   output logic [ITER_W-1:0]        bus_data,
   output logic                     bus_oe,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     timeout_err
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int HO_W  = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

   localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
   localparam logic [HO_W-1:0]  HOLD_LOAD  = HO_W'(HOLDOFF - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t              r_state;
   logic                r_req;
   logic [HO_W-1:0]     r_hold;
   logic [PTR_W-1:0]    r_wrPtr;
   logic [PTR_W-1:0]    r_rdPtr;
   logic [CNT_W-1:0]    r_count;
   logic [ADDR_W-1:0]   r_addrMem [DEPTH];
   logic [ITER_W-1:0]   r_iterMem [DEPTH];

   logic                w_ready;
   logic                w_push;
   logic                w_pop;

   // A full FIFO refuses pushes even when a pop happens in the same cycle;
   // the freed slot only becomes visible once the count has been updated.
   assign w_ready = (r_count != FULL_COUNT);
   assign w_push  = res_valid & w_ready;

   // A grant only pops while the request is actually up. REQ is only entered
   // with a non-empty FIFO and nothing else pops, so the head is valid here.
   assign w_pop   = req_ack & (r_state == REQ);

   assign res_ready  = w_ready;
   assign engine_req = r_req;
   assign fifo_count = r_count;
   assign bus_oe     = w_pop;
   assign bus_addr   = w_pop ? r_addrMem[r_rdPtr] : '0;
   assign bus_data   = w_pop ? r_iterMem[r_rdPtr] : '0;

   // Storage array: written on push only, so it needs no reset. Stale contents
   // are never observed because the bus is gated by bus_oe.
   always_ff @(posedge clk_iCLK) begin
      if (w_push) begin
         r_addrMem[r_wrPtr] <= res_addr;
         r_iterMem[r_wrPtr] <= res_iter;
      end
   end

   // FIFO pointers and occupancy. DEPTH is a power of two, so the pointers
   // wrap naturally. A simultaneous push and pop leaves the count unchanged.
   always_ff @(posedge clk_iCLK or negedge reset_n) begin
      if (!reset_n) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wrPtr <= r_wrPtr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Request FSM. IDLE looks at the registered count, which gives the
   // one-cycle push-to-request latency. HOLD also counts a push arriving in
   // its final cycle so a fresh result does not wait for an extra IDLE pass.
   always_ff @(posedge clk_iCLK or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_req   <= 1'b0;
         r_hold  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (r_count != '0) begin
                  r_state <= REQ;
                  r_req   <= 1'b1;
               end
            end
            REQ: begin
               if (req_ack) begin
                  r_state <= HOLD;
                  r_req   <= 1'b0;
                  r_hold  <= HOLD_LOAD;
               end
            end
            HOLD: begin
               if (r_hold != '0) begin
                  r_hold <= r_hold - HO_W'(1);
               end else if ((r_count != '0) || w_push) begin
                  r_state <= REQ;
                  r_req   <= 1'b1;
               end else begin
                  r_state <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
               r_req   <= 1'b0;
            end
         endcase
      end
   end

`ifdef ERP_ACK_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT + 1);

   logic [TO_W-1:0] r_toCnt;
   logic            r_toErr;

   // Watchdog: counts cycles spent waiting in REQ, restarts whenever REQ is
   // left. The flag is sticky; the request itself is never withdrawn and no
   // data is dropped, so a late grant still completes normally.
   always_ff @(posedge clk_iCLK or negedge reset_n) begin
      if (!reset_n) begin
         r_toCnt <= '0;
         r_toErr <= 1'b0;
      end else if ((r_state == REQ) && !req_ack) begin
         if (r_toCnt != TO_W'(TIMEOUT)) begin
            r_toCnt <= r_toCnt + TO_W'(1);
         end
         if (r_toCnt == TO_W'(TIMEOUT - 1)) begin
            r_toErr <= 1'b1;
         end
      end else begin
         r_toCnt <= '0;
      end
   end

   assign timeout_err = r_toErr;
`else
   assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_engine_result_port.sv
`timescale 1ns/1ps
// Self-checking bench for engine_result_port: a table of per-cycle vectors
// covers the single-pixel write, fill/drain ordering and grants outside REQ;
// hand-written sequences cover pointer wrap with simultaneous push/pop,
// asynchronous reset during a grant, and the ack watchdog.

module tb_engine_result_port;

   localparam int ADDR_W  = 19;
   localparam int ITER_W  = 8;
   localparam int DEPTH   = 4;
   localparam int HOLDOFF = 2;
   localparam int TIMEOUT = 16;

`ifdef ERP_ACK_TIMEOUT_EN
   localparam logic EXP_TO_ERR = 1'b1;
`else
   localparam logic EXP_TO_ERR = 1'b0;
`endif

   logic                clk;
   logic                resetN;
   logic                resValid;
   logic                resReady;
   logic [ADDR_W-1:0]   resAddr;
   logic [ITER_W-1:0]   resIter;
   logic                engineReq;
   logic                reqAck;
   logic [ADDR_W-1:0]   busAddr;
   logic [ITER_W-1:0]   busData;
   logic                busOe;
   logic [2:0]          fifoCount;
   logic                timeoutErr;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic              valid;
      logic [ADDR_W-1:0] addr;
      logic [ITER_W-1:0] iter;
      logic              ack;
      logic              expReady;
      logic              expReq;
      logic              expOe;
      logic [ADDR_W-1:0] expAddr;
      logic [ITER_W-1:0] expData;
      logic [2:0]        expCount;
   } vec_t;

   vec_t vecs[$];
   logic [26:0] model[$];

   engine_result_port #(
      .ADDR_W  (ADDR_W),
      .ITER_W  (ITER_W),
      .DEPTH   (DEPTH),
      .HOLDOFF (HOLDOFF),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk_iCLK    (clk),
      .reset_n     (resetN),
      .res_valid   (resValid),
      .res_ready   (resReady),
      .res_addr    (resAddr),
      .res_iter    (resIter),
      .engine_req  (engineReq),
      .req_ack     (reqAck),
      .bus_addr    (busAddr),
      .bus_data    (busData),
      .bus_oe      (busOe),
      .fifo_count  (fifoCount),
      .timeout_err (timeoutErr)
   );

   // Free-running 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case some wait is never satisfied.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got running required finished");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h required 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Drive one cycle's inputs at the falling edge, then settle before checks.
   task automatic applyStimulus(input logic v, input logic [ADDR_W-1:0] a,
                                input logic [ITER_W-1:0] it, input logic ack);
      @(negedge clk);
      resValid = v;
      resAddr  = a;
      resIter  = it;
      reqAck   = ack;
      #1;
   endtask

   // Idle cycles until the request is up, bounded.
   task automatic waitReq(output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 20; k++) begin
         applyStimulus(1'b0, '0, '0, 1'b0);
         if (engineReq) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         checkOutput("wait_req", 32'(engineReq), 32'd1);
      end
   endtask

   function automatic vec_t mkVec(logic v, logic [ADDR_W-1:0] a, logic [ITER_W-1:0] it,
                                  logic ack, logic rdy, logic req, logic oe,
                                  logic [ADDR_W-1:0] ea, logic [ITER_W-1:0] ed,
                                  logic [2:0] cnt);
      vec_t r;
      r.valid = v;   r.addr = a;    r.iter = it;   r.ack = ack;
      r.expReady = rdy; r.expReq = req; r.expOe = oe;
      r.expAddr = ea; r.expData = ed; r.expCount = cnt;
      return r;
   endfunction

   initial begin
      bit ok;
      int writes;
      logic [26:0] head;
      logic [26:0] item;
      logic        expReady;

      resetN   = 1'b0;
      resValid = 1'b0;
      resAddr  = '0;
      resIter  = '0;
      reqAck   = 1'b0;

      // ---- reset state ----
      #12;
      checkOutput("rst_ready", 32'(resReady),   32'd1);
      checkOutput("rst_req",   32'(engineReq),  32'd0);
      checkOutput("rst_oe",    32'(busOe),      32'd0);
      checkOutput("rst_addr",  32'(busAddr),    32'd0);
      checkOutput("rst_data",  32'(busData),    32'd0);
      checkOutput("rst_count", 32'(fifoCount),  32'd0);
      checkOutput("rst_err",   32'(timeoutErr), 32'd0);
      @(negedge clk);
      resetN = 1'b1;

      // ---- vector table: single write, ack in IDLE, fill/drain, ack in HOLD ----
      //                  valid addr       iter   ack  rdy req oe  busAddr    busData cnt
      vecs.push_back(mkVec(1, 19'h00123, 8'h2A, 0,   1,  0,  0,  19'h0,     8'h0,   0));
      vecs.push_back(mkVec(0, 19'h0,     8'h0,  0,   1,  0,  0,  19'h0,     8'h0,   1));
      vecs.push_back(mkVec(0, 19'h0,     8'h0,  0,   1,  1,  0,  19'h0,     8'h0,   1));
      vecs.push_back(mkVec(0, 19'h0,     8'h0,  0,   1,  1,  0,  19'h0,     8'h0,   1));
      vecs.push_back(mkVec(0, 19'h0,     8'h0,  0,   1,  1,  0,  19'h0,     8'h0,   1));
      vecs.push_back(mkVec(0, 19'h0,     8'h0,  1,   1,  1,  1,  19'h00123, 8'h2A,  1));
      vecs.push_back(mkVec(0, 19'h0,     8'h0,  0,   1,  0,  0,  19'h0,     8'h0,   0));
      vecs.push_back(mkVec(0, 19'h0,     8'h0,  0,   1,  0,  0,  19'h0,     8'h0,   0));
      vecs.push_back(mkVec(0, 19'h0,     8'h0,  1,   1,  0,  0,  19'h0,     8'h0,   0));
      vecs.push_back(mkVec(1, 19'h00A01, 8'h11, 0,   1,  0,  0,  19'h0,     8'h0,   0));
      vecs.push_back(mkVec(1, 19'h00A02, 8'h12, 0,   1,  0,  0,  19'h0,     8'h0,   1));
      vecs.push_back(mkVec(1, 19'h00A03, 8'h13, 0,   1,  1,  0,  19'h0,     8'h0,   2));
      vecs.push_back(mkVec(1, 19'h00A04, 8'h14, 0,   1,  1,  0,  19'h0,     8'h0,   3));
      vecs.push_back(mkVec(1, 19'h00A05, 8'h15, 0,   0,  1,  0,  19'h0,     8'h0,   4));
      vecs.push_back(mkVec(0, 19'h0,     8'h0,  1,   0,  1,  1,  19'h00A01, 8'h11,  4));
      vecs.push_back(mkVec(0, 19'h0,     8'h0,  1,   1,  0,  0,  19'h0,     8'h0,   3));
      vecs.push_back(mkVec(0, 19'h0,     8'h0,  0,   1,  0,  0,  19'h0,     8'h0,   3));
      vecs.push_back(mkVec(0, 19'h0,     8'h0,  1,   1,  1,  1,  19'h00A02, 8'h12,  3));
      vecs.push_back(mkVec(0, 19'h0,     8'h0,  0,   1,  0,  0,  19'h0,     8'h0,   2));
      vecs.push_back(mkVec(0, 19'h0,     8'h0,  0,   1,  0,  0,  19'h0,     8'h0,   2));
      vecs.push_back(mkVec(0, 19'h0,     8'h0,  1,   1,  1,  1,  19'h00A03, 8'h13,  2));
      vecs.push_back(mkVec(0, 19'h0,     8'h0,  0,   1,  0,  0,  19'h0,     8'h0,   1));
      vecs.push_back(mkVec(0, 19'h0,     8'h0,  0,   1,  0,  0,  19'h0,     8'h0,   1));
      vecs.push_back(mkVec(0, 19'h0,     8'h0,  1,   1,  1,  1,  19'h00A04, 8'h14,  1));
      vecs.push_back(mkVec(0, 19'h0,     8'h0,  0,   1,  0,  0,  19'h0,     8'h0,   0));
      vecs.push_back(mkVec(0, 19'h0,     8'h0,  0,   1,  0,  0,  19'h0,     8'h0,   0));
      vecs.push_back(mkVec(0, 19'h0,     8'h0,  1,   1,  0,  0,  19'h0,     8'h0,   0));

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].valid, vecs[i].addr, vecs[i].iter, vecs[i].ack);
         checkOutput($sformatf("vec%0d_ready", i), 32'(resReady),  32'(vecs[i].expReady));
         checkOutput($sformatf("vec%0d_req", i),   32'(engineReq), 32'(vecs[i].expReq));
         checkOutput($sformatf("vec%0d_oe", i),    32'(busOe),     32'(vecs[i].expOe));
         checkOutput($sformatf("vec%0d_addr", i),  32'(busAddr),   32'(vecs[i].expAddr));
         checkOutput($sformatf("vec%0d_data", i),  32'(busData),   32'(vecs[i].expData));
         checkOutput($sformatf("vec%0d_count", i), 32'(fifoCount), 32'(vecs[i].expCount));
      end

      // ---- pointer wrap: grants with pushes at count 3 (accepted) and 4 (refused) ----
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, ADDR_W'(19'h00B00 + i), ITER_W'(8'h30 + i), 1'b0);
         model.push_back({ADDR_W'(19'h00B00 + i), ITER_W'(8'h30 + i)});
      end
      for (int it = 0; it < 12; it++) begin
         waitReq(ok);
         if (!ok) break;
         item = {ADDR_W'(19'h00C00 + it), ITER_W'(8'h40 + it)};
         applyStimulus(1'b1, item[26:8], item[7:0], 1'b1);
         head     = model[0];
         expReady = (model.size() != DEPTH);
         checkOutput("rot_oe",    32'(busOe),     32'd1);
         checkOutput("rot_addr",  32'(busAddr),   32'(head[26:8]));
         checkOutput("rot_data",  32'(busData),   32'(head[7:0]));
         checkOutput("rot_count", 32'(fifoCount), 32'(model.size()));
         checkOutput("rot_ready", 32'(resReady),  32'(expReady));
         void'(model.pop_front());
         if (expReady) model.push_back(item);
         if (it % 2 == 1) begin
            item = {ADDR_W'(19'h00D80 + it), ITER_W'(8'h80 + it)};
            applyStimulus(1'b1, item[26:8], item[7:0], 1'b0);
            checkOutput("rot_hold_req",   32'(engineReq), 32'd0);
            checkOutput("rot_hold_count", 32'(fifoCount), 32'(model.size()));
            model.push_back(item);
         end
      end
      for (int k = 0; k < 8 && model.size() > 0; k++) begin
         waitReq(ok);
         if (!ok) break;
         applyStimulus(1'b0, '0, '0, 1'b1);
         head = model.pop_front();
         checkOutput("drain_addr", 32'(busAddr), 32'(head[26:8]));
         checkOutput("drain_data", 32'(busData), 32'(head[7:0]));
      end
      checkOutput("drain_left", 32'(model.size()), 32'd0);
      repeat (3) applyStimulus(1'b0, '0, '0, 1'b0);
      checkOutput("drain_count", 32'(fifoCount), 32'd0);
      checkOutput("drain_req",   32'(engineReq), 32'd0);

      // ---- asynchronous reset in the middle of a grant with count 3 ----
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, ADDR_W'(19'h00E00 + i), 8'h55, 1'b0);
      end
      waitReq(ok);
      applyStimulus(1'b0, '0, '0, 1'b1);
      checkOutput("grant_oe", 32'(busOe), 32'd1);
      #2;
      resetN = 1'b0;
      #1;
      checkOutput("arst_req",   32'(engineReq), 32'd0);
      checkOutput("arst_oe",    32'(busOe),     32'd0);
      checkOutput("arst_addr",  32'(busAddr),   32'd0);
      checkOutput("arst_count", 32'(fifoCount), 32'd0);
      checkOutput("arst_ready", 32'(resReady),  32'd1);
      @(negedge clk);
      resetN = 1'b1;
      writes = 0;
      for (int k = 0; k < 10; k++) begin
         applyStimulus(1'b0, '0, '0, 1'b1);
         if (busOe || engineReq) writes++;
      end
      checkOutput("arst_no_write", 32'(writes),    32'd0);
      checkOutput("arst_count2",   32'(fifoCount), 32'd0);

      // ---- ack watchdog ----
      applyStimulus(1'b1, 19'h00F00, 8'h77, 1'b0);
      waitReq(ok);
      repeat (10) applyStimulus(1'b0, '0, '0, 1'b0);
      checkOutput("to_early", 32'(timeoutErr), 32'd0);
      repeat (20) applyStimulus(1'b0, '0, '0, 1'b0);
      checkOutput("to_req_held", 32'(engineReq),  32'd1);
      checkOutput("to_set",      32'(timeoutErr), 32'(EXP_TO_ERR));
      applyStimulus(1'b0, '0, '0, 1'b1);
      checkOutput("to_late_oe",   32'(busOe),   32'd1);
      checkOutput("to_late_data", 32'(busData), 32'h77);
      repeat (4) applyStimulus(1'b0, '0, '0, 1'b0);
      checkOutput("to_sticky", 32'(timeoutErr), 32'(EXP_TO_ERR));
      checkOutput("to_count",  32'(fifoCount),  32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
